seg7_scan_decoder: RTL and testbench

// Receive side of the multiplexed seven-segment bus (seg/an) driven by the calculator display path.

---
 rtl/seg7_scan_decoder_if.sv | 24 ++
 rtl/seg7_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Multiplexed seven-segment display bus (segments + anodes, both active-low).
//   seg  [6:0]            segments {g,f,e,d,c,b,a}, active-low
//   an   [NUM_DIGITS-1:0] anodes, active-low, one-hot while a digit is lit
//   dp                    decimal point, active-low (only with SEG7_DP_EN)
// Modports: master drives the display, slave watches it.
// Optional feature macro: SEG7_DP_EN (adds the dp line).
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 8
);
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;
`ifdef SEG7_DP_EN
   logic                  dp;

   modport master (output seg, output an, output dp);
   modport slave  (input  seg, input  an, input  dp);
`else
   modport master (output seg, output an);
   modport slave  (input  seg, input  an);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Receive side of a scanned seven-segment display. Waits for each {an,seg}
// pattern to settle, decodes the lit digit back to a hex nibble and flags
// when every digit in DIGIT_MASK has been captured (one display frame).
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   bus           seg7_scan_decoder_if.slave (seg, an[, dp])
//   digit_val     decoded nibble per digit, digit i = [4i+3:4i]
//   digit_vld     digit i holds a valid hex decode
//   digit_blank   digit i last captured as blank (seg = 7'h7F)
//   frame_done    1-cycle pulse: all DIGIT_MASK digits captured since last pulse
//   err_pattern   1-cycle pulse: captured pattern not in the decode table
//   err_anode     1-cycle pulse: stable pattern with more than one anode low
//   digit_dp      per-digit decimal point, active-high (only with SEG7_DP_EN)
// Optional feature macro: SEG7_DP_EN (decimal point compare and report).
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
   parameter int                    NUM_DIGITS    = 8,
   parameter int                    SETTLE_CYCLES = 4,
   parameter logic [NUM_DIGITS-1:0] DIGIT_MASK    = {NUM_DIGITS{1'b1}}
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seg7_scan_decoder_if.slave      bus,
   output logic [4*NUM_DIGITS-1:0] digit_val,
   output logic [NUM_DIGITS-1:0]   digit_vld,
   output logic [NUM_DIGITS-1:0]   digit_blank,
`ifdef SEG7_DP_EN
   output logic [NUM_DIGITS-1:0]   digit_dp,
`endif
   output logic                    frame_done,
   output logic                    err_pattern,
   output logic                    err_anode
);

`ifdef SEG7_DP_EN
   localparam int SW = NUM_DIGITS + 8;
`else
   localparam int SW = NUM_DIGITS + 7;
`endif
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   typedef struct packed {
      logic       ok;
      logic       blank;
      logic [3:0] nib;
   } dec_t;

   function automatic dec_t decode(input logic [6:0] s);
      dec_t d;
      d = '{ok: 1'b1, blank: 1'b0, nib: 4'h0};
      case (s)
         7'h40: d.nib = 4'h0;
         7'h79: d.nib = 4'h1;
         7'h24: d.nib = 4'h2;
         7'h30: d.nib = 4'h3;
         7'h19: d.nib = 4'h4;
         7'h12: d.nib = 4'h5;
         7'h02: d.nib = 4'h6;
         7'h78: d.nib = 4'h7;
         7'h00: d.nib = 4'h8;
         7'h10: d.nib = 4'h9;
         7'h08: d.nib = 4'hA;
         7'h03: d.nib = 4'hB;
         7'h46: d.nib = 4'hC;
         7'h21: d.nib = 4'hD;
         7'h06: d.nib = 4'hE;
         7'h0E: d.nib = 4'hF;
         7'h7F: begin d.ok = 1'b0; d.blank = 1'b1; end
         default: d.ok = 1'b0;
      endcase
      return d;
   endfunction

   state_t                state;
   logic [SW-1:0]         samp;
   logic [SW-1:0]         in_w;
   logic [CW-1:0]         cnt;
   logic [NUM_DIGITS-1:0] seen;
   logic [NUM_DIGITS-1:0] an_low;
   logic [NUM_DIGITS-1:0] seen_next;
   logic                  chg;
   logic                  all_high;
   logic                  settled;
   dec_t                  dec;

`ifdef SEG7_DP_EN
   assign in_w = {bus.dp, bus.an, bus.seg};
`else
   assign in_w = {bus.an, bus.seg};
`endif
   assign an_low    = ~bus.an;
   assign all_high  = &bus.an;
   assign chg       = (in_w != samp);
   // A pattern counts as settled on the edge that sees it for the
   // SETTLE_CYCLES-th consecutive time after the change was sampled.
   assign settled   = !chg && (cnt == CNT_LAST);
   assign seen_next = seen | an_low;
   assign dec       = decode(bus.seg);

   // NOTE: every register, including the per-digit output bank, is reset so
   // the display state is defined immediately after rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         samp        <= '0;
         cnt         <= '0;
         seen        <= '0;
         digit_val   <= '0;
         digit_vld   <= '0;
         digit_blank <= '0;
`ifdef SEG7_DP_EN
         digit_dp    <= '0;
`endif
         frame_done  <= 1'b0;
         err_pattern <= 1'b0;
         err_anode   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the compare below uses
         // the previous sample, not the one being written on this edge.
         samp        <= in_w;
         frame_done  <= 1'b0;
         err_pattern <= 1'b0;
         err_anode   <= 1'b0;
         if (chg)
            cnt <= '0;
         else if (cnt != CNT_LAST)
            cnt <= cnt + CW'(1);

         case (state)
            IDLE: begin
               if (!all_high) state <= SETTLE;
            end
            SETTLE: begin
               if (chg) begin
                  state <= all_high ? IDLE : SETTLE;
               end else if (settled) begin
                  state <= HELD;
                  if (!$onehot(an_low)) begin
                     err_anode <= 1'b1;
                  end else begin
                     for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (an_low[i]) begin
                           // An invalid pattern leaves the previous nibble in place.
                           if (dec.ok || dec.blank)
                              digit_val[4*i +: 4] <= dec.nib;
                           digit_vld[i]   <= dec.ok;
                           digit_blank[i] <= dec.blank;
`ifdef SEG7_DP_EN
                           digit_dp[i]    <= ~bus.dp;
`endif
                        end
                     end
                     err_pattern <= !(dec.ok || dec.blank);
                     if ((seen_next & DIGIT_MASK) == DIGIT_MASK) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                     end else begin
                        seen <= seen_next;
                     end
                  end
               end
            end
            HELD: begin
               if (chg) state <= all_high ? IDLE : SETTLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder (8 digits, settle 4, full mask).
// A behavioural model predicts the outputs after each capture; predictions
// are queued when a pattern is driven and popped on the capture edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   localparam int ND     = 8;
   localparam int SETTLE = 4;

   typedef struct {
      logic [31:0] val;
      logic [7:0]  vld;
      logic [7:0]  blank;
      logic        frame;
      logic        errp;
      logic        erra;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

   logic [31:0] digit_val;
   logic [7:0]  digit_vld;
   logic [7:0]  digit_blank;
`ifdef SEG7_DP_EN
   logic [7:0]  digit_dp;
`endif
   logic        frame_done;
   logic        err_pattern;
   logic        err_anode;

   seg7_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SETTLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .digit_val   (digit_val),
      .digit_vld   (digit_vld),
      .digit_blank (digit_blank),
`ifdef SEG7_DP_EN
      .digit_dp    (digit_dp),
`endif
      .frame_done  (frame_done),
      .err_pattern (err_pattern),
      .err_anode   (err_anode)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   exp_t        sb[$];
   exp_t        cur;
   logic [7:0]  m_seen;
   logic [6:0]  hex_tab [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input exp_t e);
      check({tag, ".val"},   digit_val,   e.val);
      check({tag, ".vld"},   32'(digit_vld),   32'(e.vld));
      check({tag, ".blank"}, 32'(digit_blank), 32'(e.blank));
      check({tag, ".frame"}, 32'(frame_done),  32'(e.frame));
      check({tag, ".errp"},  32'(err_pattern), 32'(e.errp));
      check({tag, ".erra"},  32'(err_anode),   32'(e.erra));
   endtask

   function automatic exp_t quiet(input exp_t e);
      exp_t q;
      q = e;
      q.frame = 1'b0;
      q.errp  = 1'b0;
      q.erra  = 1'b0;
      return q;
   endfunction

   // Model of one capture of pattern (a,s); updates the seen mask and returns
   // the output state expected right after the capture edge.
   function automatic exp_t predict(input exp_t base, input logic [7:0] a, input logic [6:0] s);
      exp_t e;
      int   lows;
      int   idx;
      int   nib;
      e    = quiet(base);
      lows = 0;
      idx  = 0;
      for (int i = 0; i < ND; i++) if (!a[i]) begin lows++; idx = i; end
      if (lows > 1) begin
         e.erra = 1'b1;
         return e;
      end
      nib = -1;
      for (int n = 0; n < 16; n++) if (hex_tab[n] == s) nib = n;
      if (nib >= 0) begin
         e.val[4*idx +: 4] = 4'(nib);
         e.vld[idx]   = 1'b1;
         e.blank[idx] = 1'b0;
      end else if (s == 7'h7F) begin
         e.val[4*idx +: 4] = 4'h0;
         e.vld[idx]   = 1'b0;
         e.blank[idx] = 1'b1;
      end else begin
         e.vld[idx]   = 1'b0;
         e.blank[idx] = 1'b0;
         e.errp       = 1'b1;
      end
      m_seen[idx] = 1'b1;
      if (m_seen == 8'hFF) begin
         e.frame = 1'b1;
         m_seen  = 8'h00;
      end
      return e;
   endfunction

   // Drive (a,s) for 'hold' edges. A capture is expected on edge SETTLE+1
   // when the pattern lights a digit and is held long enough.
   task automatic present(input string tag, input logic [7:0] a, input logic [6:0] s, input int hold);
      logic will;
      exp_t e;
      @(negedge clk);
      bus.an  = a;
      bus.seg = s;
      will = (a != 8'hFF) && (hold >= SETTLE + 1);
      if (will) sb.push_back(predict(cur, a, s));
      for (int k = 1; k <= hold; k++) begin
         @(posedge clk);
         #1;
         if (will && k == SETTLE + 1) begin
            check({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_state({tag, ".cap"}, e);
               cur = quiet(e);
            end
         end else begin
            check_state({tag, ".hold"}, cur);
         end
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n   = 1'b0;
      bus.an  = 8'hFF;
      bus.seg = 7'h7F;
      #1;
      cur    = '{val: 32'h0, vld: 8'h0, blank: 8'h0, frame: 1'b0, errp: 1'b0, erra: 1'b0};
      m_seen = 8'h00;
      check_state({tag, ".in_reset"}, cur);
      check({tag, ".sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      bus.an  = 8'hFF;
      bus.seg = 7'h7F;
`ifdef SEG7_DP_EN
      bus.dp  = 1'b1;
`endif
      do_reset("reset");
      present("idle", 8'hFF, 7'h7F, 3);

      // Single digit: capture lands on the fifth edge.
      present("d0_two", 8'hFE, 7'h24, 6);

      // Ghosting: a pattern that changes mid-settle is never captured.
      present("gap", 8'hFF, 7'h7F, 2);
      present("ghost2", 8'hFE, 7'h24, 3);
      present("five", 8'hFE, 7'h12, 6);
      check("ghost.d0", 32'(digit_val[3:0]), 32'h5);

      // Full scan 0..7 -> exactly one frame pulse on the digit-7 capture.
      for (int d = 0; d < ND; d++)
         present($sformatf("scan%0d", d), ~(8'h01 << d), hex_tab[d], 6);
      check("scan.val", digit_val, 32'h76543210);
      check("scan.vld", 32'(digit_vld), 32'hFF);

      // Blank, then invalid pattern on the same digit.
      present("blank2", 8'hFB, 7'h7F, 6);
      check("blank2.bit", 32'(digit_blank[2]), 32'd1);
      present("bad2", 8'hFB, 7'h55, 6);
      check("bad2.held", 32'(digit_val[11:8]), 32'h0);

      // Two anodes low: error pulse only.
      present("multi", 8'hFC, 7'h24, 6);

      // Reset mid-frame, then a full rescan is needed.
      for (int d = 0; d < 4; d++)
         present($sformatf("pre%0d", d), ~(8'h01 << d), hex_tab[8 + d], 6);
      do_reset("midreset");
      for (int d = 0; d < ND; d++)
         present($sformatf("rescan%0d", d), ~(8'h01 << d), hex_tab[15 - d], 6);
      check("rescan.val", digit_val, 32'h89ABCDEF);
      present("tail", 8'hFF, 7'h7F, 3);
      check("final.sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
